// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the run sequencer that sits beside the single-cycle core.
// State encoding, default timing constants and the PC width.
package proc_ctrl_pkg;

    localparam int PC_W             = 64;
    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_WATCHDOG_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } run_state_e;

endpackage

// File: rtl/run_watchdog.sv
// Saturating RUN-cycle counter.
// The expired output flags that the count has reached MAX.
module run_watchdog #(
    parameter int CNT_W = 16,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (en && (count_q != MAX_C)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == MAX_C);

endmodule

// File: rtl/proc_run_ctrl.sv
// Run sequencer: holds the core in reset, releases it at start_pc, and judges
// the run by end address, writeback value and a RUN-cycle watchdog.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | core held in reset, waiting for start
//   ST_HOLD    | core held in reset for RESET_CYCLES with new start PC
//   ST_RUN     | core running, watching currentpc and the watchdog
//   ST_DONE    | end PC reached, pass holds the compare result
//   ST_TIMEOUT | watchdog expired before the end PC was reached
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int WATCHDOG_MAX = DEF_WATCHDOG_MAX,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  start_pc,
    input  logic [PC_W-1:0]  end_pc,
    input  logic [PC_W-1:0]  expected,
    input  logic [PC_W-1:0]  currentpc,
    input  logic [PC_W-1:0]  MemtoRegOut,
    output logic             core_resetl,
    output logic [PC_W-1:0]  core_startpc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);

    run_state_e        state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [PC_W-1:0]   end_q;
    logic [PC_W-1:0]   exp_q;
    logic              core_resetl_q;
    logic [PC_W-1:0]   core_startpc_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              timeout_q;

    logic accept_start;
    logic complete;
    logic wd_en;
    logic wd_expired;

    assign accept_start = start && (state_q inside {ST_IDLE, ST_DONE, ST_TIMEOUT});
    assign complete     = (currentpc >= end_q);
    // Count is frozen on the completing cycle and on abort.
    assign wd_en        = (state_q == ST_RUN) && !abort && !complete;

    run_watchdog #(
        .CNT_W (CNT_W),
        .MAX   (WATCHDOG_MAX)
    ) u_watchdog (
        .clk     (CLK),
        .reset   (reset),
        .clr     (accept_start),
        .en      (wd_en),
        .count   (cycle_count),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            hold_q         <= '0;
            end_q          <= '0;
            exp_q          <= '0;
            core_resetl_q  <= 1'b0;
            core_startpc_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start) begin
                        state_q        <= ST_HOLD;
                        hold_q         <= HOLD_INIT;
                        core_startpc_q <= start_pc;
                        end_q          <= end_pc;
                        exp_q          <= expected;
                        core_resetl_q  <= 1'b0;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        pass_q         <= 1'b0;
                        timeout_q      <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        state_q       <= ST_IDLE;
                        core_resetl_q <= 1'b0;
                        busy_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                    end else if (hold_q == '0) begin
                        state_q       <= ST_RUN;
                        core_resetl_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q       <= ST_IDLE;
                        core_resetl_q <= 1'b0;
                        busy_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                    end else if (complete) begin
                        state_q       <= ST_DONE;
                        core_resetl_q <= 1'b0;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        pass_q        <= (MemtoRegOut == exp_q);
                    end else if (wd_expired) begin
                        state_q       <= ST_TIMEOUT;
                        core_resetl_q <= 1'b0;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    core_resetl_q <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign core_resetl  = core_resetl_q;
    assign core_startpc = core_startpc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;

endmodule
